// File: rtl/ccff_chain_ctrl.sv
// Configuration-chain sequencer: serializes host words onto a ccff chain and
// performs non-destructive readback by recirculating ccff_tail into ccff_head.
module ccff_chain_ctrl #(
    parameter int CHAIN_LEN = 40,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              cmd_valid,
    input  logic              cmd_op,
    output logic              cmd_ready,
    input  logic              abort,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [WORD_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done
);
    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_CAPT,
        S_PUSH
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WB_W-1:0]   r_word_bits;
    logic [WORD_W-1:0] r_wsr;
    logic [WORD_W-1:0] r_rsr;
    logic              r_done;

    logic [CNT_W-1:0]  w_bit_nxt;
    logic [CNT_W-1:0]  w_remain;
    logic [WB_W-1:0]   w_load;
    logic              w_last_bit;

    always_comb begin
        w_bit_nxt  = r_bit_cnt + CNT_W'(1);
        w_remain   = CNT_W'(CHAIN_LEN) - r_bit_cnt;
        w_load     = (32'(w_remain) < 32'(WORD_W)) ? WB_W'(w_remain) : WB_W'(WORD_W);
        w_last_bit = (w_bit_nxt == CNT_W'(CHAIN_LEN));
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_word_bits <= '0;
            r_wsr       <= '0;
            r_rsr       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_valid) begin
                            r_bit_cnt   <= '0;
                            r_word_bits <= '0;
                            r_rsr       <= '0;
                            r_state     <= cmd_op ? S_CAPT : S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (wr_valid) begin
                            r_wsr       <= wr_data;
                            r_word_bits <= w_load;
                            r_state     <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        r_wsr       <= r_wsr >> 1;
                        r_bit_cnt   <= w_bit_nxt;
                        r_word_bits <= r_word_bits - WB_W'(1);
                        if (r_word_bits == WB_W'(1)) begin
                            if (w_last_bit) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                    S_CAPT: begin
                        // r_word_bits counts up here: it is the fill position of the readback word
                        for (int unsigned i = 0; i < WORD_W; i++) begin
                            if (WB_W'(i) == r_word_bits) begin
                                r_rsr[i] <= ccff_tail;
                            end
                        end
                        r_bit_cnt   <= w_bit_nxt;
                        r_word_bits <= r_word_bits + WB_W'(1);
                        if ((r_word_bits == WB_W'(WORD_W - 1)) || w_last_bit) begin
                            r_state <= S_PUSH;
                        end
                    end
                    S_PUSH: begin
                        if (rd_ready) begin
                            if (r_bit_cnt == CNT_W'(CHAIN_LEN)) begin
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_rsr       <= '0;
                                r_word_bits <= '0;
                                r_state     <= S_CAPT;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign wr_ready      = (r_state == S_FETCH);
    assign rd_valid      = (r_state == S_PUSH);
    assign rd_data       = r_rsr;
    assign done          = r_done;
    assign ccff_shift_en = (r_state == S_SHIFT) || (r_state == S_CAPT);
    assign ccff_head     = (r_state == S_SHIFT) ? r_wsr[0] :
                           (r_state == S_CAPT)  ? ccff_tail : 1'b0;

endmodule

// File: tb/tb_ccff_chain_ctrl.sv
// Scoreboard bench for ccff_chain_ctrl: a 40-bit and a 13-bit instance, each
// attached to a behavioural chain model.
module tb_ccff_chain_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_op    [2];
    logic       cmd_ready [2];
    logic       abort_i   [2];
    logic       wr_valid  [2];
    logic       wr_ready  [2];
    logic [7:0] wr_data   [2];
    logic       rd_valid  [2];
    logic       rd_ready  [2];
    logic [7:0] rd_data   [2];
    logic       head      [2];
    logic       shen      [2];
    logic       tail      [2];
    logic       busy      [2];
    logic       done      [2];

    logic [39:0] ch0;
    logic [12:0] ch1;

    int n_vec = 0;
    int n_err = 0;

    logic       q_hd0 [$];
    logic       q_hd1 [$];
    logic [7:0] q_rd0 [$];
    logic [7:0] q_rd1 [$];

    logic        wmode     [2];
    logic        prv_stall [2];
    logic [7:0]  prv_rd    [2];
    int          dn_cnt    [2];
    logic [39:0] hist0;
    int          hidx0;

    always #5 clk = ~clk;

    ccff_chain_ctrl #(.CHAIN_LEN(40), .WORD_W(8)) dut0 (
        .prog_clk(clk), .pReset(rst),
        .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op[0]), .cmd_ready(cmd_ready[0]),
        .abort(abort_i[0]),
        .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .wr_data(wr_data[0]),
        .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]), .rd_data(rd_data[0]),
        .ccff_head(head[0]), .ccff_shift_en(shen[0]), .ccff_tail(tail[0]),
        .busy(busy[0]), .done(done[0])
    );

    ccff_chain_ctrl #(.CHAIN_LEN(13), .WORD_W(8)) dut1 (
        .prog_clk(clk), .pReset(rst),
        .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op[1]), .cmd_ready(cmd_ready[1]),
        .abort(abort_i[1]),
        .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .wr_data(wr_data[1]),
        .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]), .rd_data(rd_data[1]),
        .ccff_head(head[1]), .ccff_shift_en(shen[1]), .ccff_tail(tail[1]),
        .busy(busy[1]), .done(done[1])
    );

    // Chain models: head enters bit 0, tail is the last flop.
    always @(posedge clk) begin
        if (shen[0] === 1'b1) ch0 <= {ch0[38:0], head[0]};
        if (shen[1] === 1'b1) ch1 <= {ch1[11:0], head[1]};
    end
    assign tail[0] = ch0[39];
    assign tail[1] = ch1[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon(input int d);
        logic       eh;
        logic [7:0] er;
        if (shen[d] && wmode[d]) begin
            if ((d == 0 && q_hd0.size() == 0) || (d == 1 && q_hd1.size() == 0)) begin
                n_vec++; n_err++;
                $display("FAIL head_extra: dut%0d shifted with no expected bit at %0t", d, $time);
            end else begin
                if (d == 0) eh = q_hd0.pop_front(); else eh = q_hd1.pop_front();
                check($sformatf("head%0d", d), head[d], eh);
            end
        end
        if (rd_valid[d]) check($sformatf("push_shen%0d", d), shen[d], 1'b0);
        if (prv_stall[d] && rd_valid[d]) check($sformatf("rd_stable%0d", d), rd_data[d], prv_rd[d]);
        if (rd_valid[d] && rd_ready[d]) begin
            if ((d == 0 && q_rd0.size() == 0) || (d == 1 && q_rd1.size() == 0)) begin
                n_vec++; n_err++;
                $display("FAIL rd_extra: dut%0d word %0h with none expected", d, rd_data[d]);
            end else begin
                if (d == 0) er = q_rd0.pop_front(); else er = q_rd1.pop_front();
                check($sformatf("rd_data%0d", d), rd_data[d], er);
            end
        end
        prv_stall[d] = rd_valid[d] && !rd_ready[d];
        prv_rd[d]    = rd_data[d];
        if (done[d]) dn_cnt[d]++;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wmode[0] && shen[0]) begin
                if (hidx0 < 40) hist0[hidx0] = head[0];
                hidx0++;
            end else if (!wmode[0]) begin
                hidx0 = 0;
            end
            mon(0);
            mon(1);
        end
    end

    task automatic chk_reset(input int d);
        check("rst_cmd_ready", cmd_ready[d], 1'b1);
        check("rst_busy", busy[d], 1'b0);
        check("rst_done", done[d], 1'b0);
        check("rst_wr_ready", wr_ready[d], 1'b0);
        check("rst_rd_valid", rd_valid[d], 1'b0);
        check("rst_rd_data", rd_data[d], 8'h00);
        check("rst_head", head[d], 1'b0);
        check("rst_shen", shen[d], 1'b0);
    endtask

    // op=0: write nw words (expected head bits derived from words);
    // op=1: readback, words holds the nw hand-computed expected words.
    task automatic run_op(input int d, input logic op, input logic [39:0] words, input int nw,
                          input int stall, input int abort_at, output int cyc, output int sh);
        int   len;
        int   k;
        int   stc;
        int   dn0;
        logic xfer;
        len = (d == 0) ? 40 : 13;
        k = 0; stc = 0; sh = 0; cyc = 0; xfer = 1'b0;
        dn0 = dn_cnt[d];
        if (!op) begin
            for (int i = 0; i < nw * 8 && i < len; i++) begin
                if (d == 0) q_hd0.push_back(words[i]); else q_hd1.push_back(words[i]);
            end
        end else begin
            for (int i = 0; i < nw; i++) begin
                if (d == 0) q_rd0.push_back(words[8*i +: 8]); else q_rd1.push_back(words[8*i +: 8]);
            end
        end
        wmode[d] = !op;
        @(posedge clk); #1;
        cmd_valid[d] = 1'b1;
        cmd_op[d]    = op;
        @(negedge clk);
        check("cmd_ready", cmd_ready[d], 1'b1);
        @(posedge clk);
        while (1) begin
            #1;
            if (cyc == 0) begin
                cmd_valid[d] = 1'b0;
                if (!op) begin
                    wr_valid[d] = 1'b1;
                    wr_data[d]  = words[7:0];
                end
            end
            if (xfer) begin
                k++;
                if (k < nw) wr_data[d] = words[8*k +: 8];
                else wr_valid[d] = 1'b0;
            end
            if (rd_valid[d]) begin
                if (stc >= stall) rd_ready[d] = 1'b1;
                else begin rd_ready[d] = 1'b0; stc++; end
            end else begin
                rd_ready[d] = 1'b0;
                stc = 0;
            end
            if (abort_i[d]) begin
                abort_i[d]  = 1'b0;
                wr_valid[d] = 1'b0;
                check("abort_idle", cmd_ready[d], 1'b1);
                check("abort_shen", shen[d], 1'b0);
                check("abort_head", head[d], 1'b0);
                break;
            end
            if (shen[d]) sh++;
            if (abort_at > 0 && sh == abort_at) abort_i[d] = 1'b1;
            @(negedge clk);
            if (done[d]) break;
            xfer = wr_valid[d] && wr_ready[d];
            if (cyc >= 400) begin
                n_vec++; n_err++;
                $display("FAIL timeout: dut%0d op %0d no done after %0d cycles", d, op, cyc);
                break;
            end
            @(posedge clk);
            cyc++;
        end
        wr_valid[d] = 1'b0;
        rd_ready[d] = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done[d], 1'b0);
        check("done_count", 32'(dn_cnt[d] - dn0), (abort_at > 0) ? 32'd0 : 32'd1);
        if (abort_at > 0) begin
            if (d == 0) q_hd0.delete(); else q_hd1.delete();
        end else begin
            check("hd_drained", (d == 0) ? q_hd0.size() : q_hd1.size(), 0);
            check("rd_drained", (d == 0) ? q_rd0.size() : q_rd1.size(), 0);
        end
        wmode[d] = 1'b0;
    endtask

    initial begin
        int          cyc;
        int          sh;
        logic [39:0] w;
        logic [39:0] expch;
        logic [39:0] snap;
        logic [12:0] exp13;
        logic [12:0] snap13;

        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_op[d] = 1'b0; abort_i[d] = 1'b0;
            wr_valid[d] = 1'b0; wr_data[d] = 8'h00; rd_ready[d] = 1'b0;
            wmode[d] = 1'b0; prv_stall[d] = 1'b0; prv_rd[d] = 8'h00; dn_cnt[d] = 0;
        end
        hidx0 = 0;
        hist0 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;

        // 40-bit write, words A5 3C FF 00 81 with wr_valid always high
        w = 40'h81_00_FF_3C_A5;
        run_op(0, 1'b0, w, 5, 0, 0, cyc, sh);
        check("wr_cycles", cyc, 45);
        check("wr_shifts", sh, 40);
        check("head_first12", hist0[11:0], 12'hCA5);
        for (int i = 0; i < 40; i++) expch[39-i] = w[i];
        check("chain_after_wr", ch0, expch);

        // readback with rd_ready immediately high
        snap = ch0;
        run_op(0, 1'b1, 40'h81_00_FF_3C_A5, 5, 0, 0, cyc, sh);
        check("rb_cycles", cyc, 45);
        check("rb_shifts", sh, 40);
        check("rb_chain_kept", ch0, snap);

        // readback with 3 stall cycles per word
        run_op(0, 1'b1, 40'h81_00_FF_3C_A5, 5, 3, 0, cyc, sh);
        check("rbst_cycles", cyc, 60);
        check("rbst_shifts", sh, 40);
        check("rbst_chain_kept", ch0, snap);

        // abort during the 17th shift, then a complete write and readback
        run_op(0, 1'b0, 40'h9A_78_56_34_12, 5, 0, 17, cyc, sh);
        check("abort_shifts", sh, 17);
        w = 40'h66_F0_0F_C3_5A;
        run_op(0, 1'b0, w, 5, 0, 0, cyc, sh);
        check("wr2_shifts", sh, 40);
        check("wr2_cycles", cyc, 45);
        for (int i = 0; i < 40; i++) expch[39-i] = w[i];
        check("chain_after_wr2", ch0, expch);
        run_op(0, 1'b1, 40'h66_F0_0F_C3_5A, 5, 0, 0, cyc, sh);
        check("rb2_shifts", sh, 40);

        // 13-bit chain: FF then 1F, second word shifts 5 bits
        w = 40'h00_00_00_1F_FF;
        run_op(1, 1'b0, w, 2, 0, 0, cyc, sh);
        check("c13_shifts", sh, 13);
        check("c13_cycles", cyc, 15);
        check("c13_chain", ch1, 13'h1FFF);
        snap13 = ch1;
        run_op(1, 1'b1, 40'h00_00_00_1F_FF, 2, 0, 0, cyc, sh);
        check("c13_rb_shifts", sh, 13);
        check("c13_rb_kept", ch1, snap13);

        // 13-bit chain: 3C then EA, upper bits of EA discarded
        w = 40'h00_00_00_EA_3C;
        run_op(1, 1'b0, w, 2, 0, 0, cyc, sh);
        check("c13b_shifts", sh, 13);
        for (int i = 0; i < 13; i++) exp13[12-i] = w[i];
        check("c13b_chain", ch1, exp13);
        run_op(1, 1'b1, 40'h00_00_00_0A_3C, 2, 2, 0, cyc, sh);
        check("c13b_rb_shifts", sh, 13);
        check("c13b_rb_kept", ch1, exp13);

        // asynchronous reset in the middle of a readback capture
        @(posedge clk); #1;
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 1'b1;
        @(posedge clk); #1;
        cmd_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check("capt_shen", shen[0], 1'b1);
        check("capt_busy", busy[0], 1'b1);
        rst = 1'b1;
        #1;
        chk_reset(0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", cmd_ready[0], 1'b1);
        check("post_rst_shen", shen[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ccff_chain_ctrl.md
# ccff_chain_ctrl

Configuration-chain sequencer for the routing tiles' ccff flip-flop chains (switch blocks, connection blocks). It accepts bitstream words from the configuration host, serializes them onto `ccff_head` with a per-bit shift enable, and supports a non-destructive readback. Readback recirculates `ccff_tail` into `ccff_head` and returns the captured words to the host. One instance drives one chain; the chain length is fixed at elaboration.

## Interface
- `CHAIN_LEN`, default 40: number of config bits in the chain (sb_0__0_ chain: 12×2 + 2×2 + 2×3 + 2×3 = 40).
- `WORD_W`, default 8: host word width.
- `CNT_W`, default $clog2(CHAIN_LEN+1): width of the bit counter.
- `prog_clk` input 1: configuration clock; every flop in this block runs on its rising edge.
- `pReset` input 1: asynchronous, active-high reset.
- `cmd_valid` input 1: command request.
- `cmd_op` input 1: 0 = write, 1 = readback.
- `cmd_ready` output 1: high only in IDLE.
- `abort` input 1: cancels the current operation.
- `wr_valid` / `wr_ready` input / output 1: write-word handshake.
- `wr_data` input WORD_W: write word, shifted LSB first.
- `rd_valid` / `rd_ready` output / input 1: readback-word handshake.
- `rd_data` output WORD_W: readback word, LSB = first bit captured.
- `ccff_head` output 1: serial data into the chain.
- `ccff_shift_en` output 1: chain clock enable; the chain captures `ccff_head` on each `prog_clk` edge where this is 1.
- `ccff_tail` input 1: chain serial output.
- `busy` output 1: not IDLE.
- `done` output 1: one-cycle pulse on normal completion.

## Operation
- States: IDLE, FETCH, SHIFT, CAPT, PUSH.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_op`, clear `bit_cnt` and the word counter.
  - Write goes to FETCH; readback goes to CAPT.
- FETCH (write)
  - `wr_ready`=1.
  - On `wr_valid`: load `wr_data` into the shift register, set `word_bits` = min(WORD_W, CHAIN_LEN − bit_cnt), go to SHIFT.
- SHIFT (write)
  - `ccff_shift_en`=1, `ccff_head` = shift register LSB (registered).
  - Each cycle: shift right by one, `bit_cnt`+1, `word_bits`−1.
  - When `word_bits` reaches 0: if `bit_cnt` == CHAIN_LEN, pulse `done` and go to IDLE; otherwise go to FETCH.
  - Unused upper bits of the final word are discarded and never shifted.
- CAPT (readback)
  - `ccff_shift_en`=1, `ccff_head` = `ccff_tail` (combinational recirculation).
  - Each cycle: capture `ccff_tail` into rd shift-register position `word_bits`, `bit_cnt`+1.
  - When the word is full or `bit_cnt` == CHAIN_LEN: go to PUSH.
- PUSH (readback)
  - `rd_valid`=1, `rd_data` held stable, no shifting.
  - On `rd_ready`: if `bit_cnt` == CHAIN_LEN, pulse `done` and go to IDLE; otherwise go to CAPT.
  - Unfilled upper bits of the final readback word are 0.
- Exactly CHAIN_LEN readback shifts are issued, so the chain contents are unchanged after a readback.
- `ccff_shift_en`=0 in IDLE, FETCH and PUSH; the chain never shifts while the block is stalled.
- `abort`
  - In any non-IDLE state: go to IDLE on the next edge, no `done` pulse, `ccff_shift_en` low from that edge.
  - Chain contents after an abort are undefined and the host reissues the command.
  - `abort` in IDLE has no effect. `abort` has priority over `cmd_valid`, `wr_valid` and `rd_ready` in the same cycle.
- `cmd_valid` outside IDLE is ignored.

## Timing
- Reset values: state = IDLE, `cmd_ready`=1, `busy`=0, `done`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `ccff_head`=0, `ccff_shift_en`=0, counters = 0.
- `ccff_head` = 0 whenever not in SHIFT or CAPT.
- Write cost per word: 1 FETCH cycle (if `wr_valid` is already high) + `word_bits` SHIFT cycles.
  - Minimum total for CHAIN_LEN=40, WORD_W=8: 5 + 40 = 45 cycles from leaving IDLE to `done`.
- Readback cost per word: `word_bits` CAPT cycles + at least 1 PUSH cycle.
- `done` is asserted in the cycle the state register returns to IDLE, i.e. `cmd_ready` is already 1 in that cycle.
- Back-to-back commands: a new `cmd_valid` is accepted in the `done` cycle.
- `pReset` asserted mid-operation clears everything immediately (asynchronous); the chain state is then undefined.
- `ccff_tail` is required to be stable a setup time before `prog_clk` (the chain sits on the same clock); the path `ccff_tail` → `ccff_head` is combinational.

## Test plan
- Write, CHAIN_LEN=40, words 0xA5, 0x3C, 0xFF, 0x00, 0x81 with `wr_valid` always high
  - `ccff_shift_en` high for exactly 40 cycles.
  - `ccff_head` sequence is 1,0,1,0,0,1,0,1,0,0,1,1,…
  - `done` pulses at cycle 45.
- Write as above, then readback against a 40-bit chain model with `rd_ready`=1
  - `rd_data` returns 0xA5, 0x3C, 0xFF, 0x00, 0x81.
  - The chain model is identical before and after the readback.
- Readback with `rd_ready` held low for 3 cycles on every word
  - `ccff_shift_en`=0 throughout each stall, `rd_data` stable.
  - Total `ccff_shift_en` cycles = 40.
- CHAIN_LEN=13, WORD_W=8, words 0xFF, 0x1F
  - 13 shifts total; the second word shifts 5 bits only.
  - Readback returns 0xFF, then 0x1F with bits [7:5]=0.
- `abort` at SHIFT cycle 17 of a write
  - IDLE next cycle, `ccff_shift_en`=0, no `done` pulse.
  - A following write completes normally with 40 shifts.
- `pReset` pulse mid-CAPT
  - All outputs take their reset values immediately, before the next clock edge.
  - `cmd_ready`=1 after release.
